// File: rtl/multiplier_control.sv
// Sequencing controller for the shift-add multiplier datapath: latches operands,
// strobes the product register load, runs WIDTH iterations, then holds Ready until Ack.
module multiplier_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Multiplicand_in,
    input  logic [WIDTH-1:0] Multiplier_in,
    input  logic             Ack,
    output logic [WIDTH-1:0] Multiplicand,
    output logic [WIDTH-1:0] Multiplier_out,
    output logic             Load,
    output logic             Run,
    output logic             pre_finish,
    output logic             Ready,
    output logic             Busy,
    output logic             Done_pulse,
    output logic [CNT_W-1:0] Count
);

    // state  | meaning
    // S_IDLE | waiting for Start, operands frozen
    // S_LOAD | one-cycle product register load strobe
    // S_RUN  | WIDTH shift-add iterations, Count = iteration index
    // S_DONE | product valid, waiting for Ack
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_done_pulse;
    logic             w_last;

    assign w_last = (r_count == LAST_CNT);

    always_comb begin
        w_next     = r_state;
        Load       = 1'b0;
        Run        = 1'b0;
        pre_finish = 1'b1;
        Ready      = 1'b0;
        Busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) w_next = S_LOAD;
            end
            S_LOAD: begin
                Load   = 1'b1;
                Busy   = 1'b1;
                w_next = S_RUN;
            end
            S_RUN: begin
                Run        = 1'b1;
                pre_finish = 1'b0;
                Busy       = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                Ready = 1'b1;
                if (Ack) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_done_pulse <= (r_state == S_RUN) && (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_mcand  <= Multiplicand_in;
                        r_mplier <= Multiplier_in;
                        r_count  <= '0;
                    end
                end
                S_LOAD: r_count <= '0;
                // Saturates at the last index so the counter can never wrap.
                S_RUN:  if (!w_last) r_count <= r_count + 1'b1;
                default: ;
            endcase
        end
    end

    assign Multiplicand   = r_mcand;
    assign Multiplier_out = r_mplier;
    assign Done_pulse     = r_done_pulse;
    assign Count          = r_count;

endmodule

// File: tb/tb_multiplier_control.sv
// Randomized and directed bench for multiplier_control, checked against a
// cycles-since-accept reference model and a behavioural shift-add product register.
module tb_multiplier_control;

    localparam int W  = 32;
    localparam int CW = 6;

    logic          clk;
    logic          Reset;
    logic          Start;
    logic [W-1:0]  Multiplicand_in;
    logic [W-1:0]  Multiplier_in;
    logic          Ack;
    logic [W-1:0]  Multiplicand;
    logic [W-1:0]  Multiplier_out;
    logic          Load;
    logic          Run;
    logic          pre_finish;
    logic          Ready;
    logic          Busy;
    logic          Done_pulse;
    logic [CW-1:0] Count;

    multiplier_control #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk             (clk),
        .Reset           (Reset),
        .Start           (Start),
        .Multiplicand_in (Multiplicand_in),
        .Multiplier_in   (Multiplier_in),
        .Ack             (Ack),
        .Multiplicand    (Multiplicand),
        .Multiplier_out  (Multiplier_out),
        .Load            (Load),
        .Run             (Run),
        .pre_finish      (pre_finish),
        .Ready           (Ready),
        .Busy            (Busy),
        .Done_pulse      (Done_pulse),
        .Count           (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: age = cycles since the accepted Start (0 = idle).
    int          age = 0;
    logic        from_reset = 1'b1;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;

    // Behavioural product register driven by the DUT's previous-cycle outputs.
    logic [63:0]  prod = '0;
    logic         prev_load = 1'b0;
    logic         prev_run  = 1'b0;
    logic         prev_pf   = 1'b1;
    logic [W-1:0] prev_mcand = '0;
    logic [W-1:0] prev_mplier = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        logic running;
        logic [63:0] exp_prod;
        running = (age >= 2) && (age <= W + 1);
        chk("Load",       64'(Load),       64'(age == 1));
        chk("Run",        64'(Run),        64'(running));
        chk("pre_finish", 64'(pre_finish), 64'(!running));
        chk("Busy",       64'(Busy),       64'((age >= 1) && (age <= W + 1)));
        chk("Ready",      64'(Ready),      64'(age >= W + 2));
        chk("Done_pulse", 64'(Done_pulse), 64'(age == W + 2));
        chk("Multiplicand",   64'(Multiplicand),   64'(m_a));
        chk("Multiplier_out", 64'(Multiplier_out), 64'(m_b));
        if (running)
            chk("Count_run", 64'(Count), 64'(age - 2));
        else if (age >= W + 2)
            chk("Count_done", 64'(Count), 64'(W - 1));
        else if (age == 0 && from_reset)
            chk("Count_reset", 64'(Count), 64'd0);
        if (age == W + 2) begin
            exp_prod = 64'(m_a) * 64'(m_b);
            chk("Product", prod, exp_prod);
        end
    endtask

    task automatic step();
        logic [32:0] sum;
        logic [64:0] cat;
        @(posedge clk);
        if (prev_load) begin
            prod = {32'd0, prev_mplier};
        end else if (prev_run && !prev_pf) begin
            sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, prev_mcand} : 33'd0);
            cat  = {sum, prod[31:0]};
            prod = cat[64:1];
        end
        if (Reset) begin
            age = 0; m_a = '0; m_b = '0; from_reset = 1'b1;
        end else if (age == 0) begin
            if (Start) begin
                age = 1; m_a = Multiplicand_in; m_b = Multiplier_in; from_reset = 1'b0;
            end
        end else if (age >= W + 2 && Ack) begin
            age = 0;
        end else begin
            age++;
        end
        #1;
        check_all();
        prev_load   = Load;
        prev_run    = Run;
        prev_pf     = pre_finish;
        prev_mcand  = Multiplicand;
        prev_mplier = Multiplier_out;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        Multiplicand_in = a;
        Multiplier_in   = b;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(a, b);
        repeat (W + 1) step();
        Ack = 1'b1;
        step();
        Ack = 1'b0;
        step();
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Ack = 1'b0;
        Multiplicand_in = '0; Multiplier_in = '0;
        repeat (2) step();
        Reset = 1'b0;
        step();

        run_op(32'h0000_0003, 32'h0000_0005);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Start pulses and operand changes while running are ignored.
        start_op(32'hCAFE_0001, 32'h0000_BEEF);
        repeat (5) step();
        Start = 1'b1; Multiplicand_in = 32'h1234_5678;
        repeat (3) step();
        Start = 1'b0;
        repeat (W + 1 - 8) step();
        Ack = 1'b1; step(); Ack = 1'b0; step();

        // Hold Ready without Ack, then release.
        start_op(32'h0001_0001, 32'h0000_FFFF);
        repeat (W + 1) step();
        repeat (10) step();
        Ack = 1'b1; step(); Ack = 1'b0; step();

        // Reset while Count == 10 aborts the operation.
        start_op(32'hDEAD_BEEF, 32'h1357_9BDF);
        repeat (11) step();
        Reset = 1'b1; Start = 1'b1; step();
        Reset = 1'b0; Start = 1'b0;
        repeat (W + 4) step();
        run_op(32'h8000_0000, 32'h0000_0002);

        // Start together with Ack in DONE is not accepted.
        start_op(32'h0000_0007, 32'h0000_0009);
        repeat (W + 1) step();
        Start = 1'b1; Ack = 1'b1; Multiplicand_in = 32'h0000_0011;
        step();
        Ack = 1'b0;
        step();
        Start = 1'b0;
        repeat (W + 2) step();
        Ack = 1'b1; step(); Ack = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            Reset = ($urandom_range(0, 299) == 0);
            Start = ($urandom_range(0, 3) == 0);
            Ack   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) Multiplicand_in = $urandom;
            if ($urandom_range(0, 3) == 0) Multiplier_in   = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multiplier_control.md
Name: multiplier_control

Overview:
Sequencing controller for the 32-bit shift-add multiplier datapath. It accepts operands under a Start/Ack handshake and latches them. It then drives the product register's load strobe (Load, which connects to the product register's Reset input) and its Run/pre_finish/Ready controls. It counts exactly WIDTH shift-add iterations and presents the latched multiplicand to the ALU.

Parameters:
WIDTH, 32, operand width and iteration count
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  clock, all state changes on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request new multiply; accepted only in IDLE
Multiplicand_in  input  WIDTH  multiplicand operand, sampled on accepted Start
Multiplier_in  input  WIDTH  multiplier operand, sampled on accepted Start
Ack  input  1  consumer has taken the result; releases DONE
Multiplicand  output  WIDTH  latched multiplicand, drives ALU operand
Multiplier_out  output  WIDTH  latched multiplier, drives product register load data
Load  output  1  one-cycle strobe; product register loads {0, Multiplier_out}
Run  output  1  high while iterating
pre_finish  output  1  low only during RUN; blocks product updates otherwise
Ready  output  1  result valid in product register
Busy  output  1  high in LOAD and RUN
Done_pulse  output  1  single-cycle pulse on entry to DONE
Count  output  CNT_W  current iteration index

Behaviour:
- Reset behaviour: Reset is synchronous, active-high; clock is clk. Reset takes priority over all other inputs.
  - On Reset: state=IDLE, Count=0.
  - Multiplicand=0, Multiplier_out=0.
  - Load=Run=Ready=Busy=Done_pulse=0, pre_finish=1.
- States: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from state; no input-to-output combinational paths.
- IDLE:
  - Start=1 → latch both operands, go to LOAD.
  - Start=0 → stay.
- LOAD (1 cycle):
  - Load=1, Busy=1.
  - Count cleared to 0.
  - Next state is RUN unconditionally.
- RUN:
  - Run=1, pre_finish=0, Busy=1.
  - Count increments each cycle from 0 to WIDTH-1.
  - At Count==WIDTH-1, the next state is DONE.
  - This gives exactly WIDTH cycles with Run&&!pre_finish, i.e. exactly WIDTH product updates.
- DONE:
  - Run=0, pre_finish=1, Ready=1.
  - Done_pulse=1 only in the first DONE cycle.
  - Count holds at WIDTH-1.
  - Ack=1 → IDLE; Ready drops in the next cycle.
- pre_finish = 1 in every state except RUN.
- Latency: with Start high in cycle t (IDLE):
  - t+1: LOAD.
  - t+2 .. t+WIDTH+1: RUN.
  - t+WIDTH+2: Ready=1, i.e. 34 cycles for WIDTH=32.
- Start outside IDLE is ignored, not queued. Operands stay frozen from acceptance until the next accepted Start.
- Ack outside DONE is ignored.
- Simultaneous Start+Ack in DONE → IDLE; that Start is not accepted. A new op needs Start in a later IDLE cycle.
- Reset mid-LOAD or mid-RUN aborts: next cycle is IDLE with reset values, and no Ready or Done_pulse is produced.
- Start and Reset in the same cycle: Reset wins, operands are cleared.
- The counter never wraps: RUN exits at WIDTH-1, and Count never exceeds WIDTH-1.

Test Plan:
1. Reset, then Start=1 for 1 cycle with Multiplicand_in=0x00000003, Multiplier_in=0x00000005 → Load high exactly 1 cycle; Run high exactly 32 cycles with pre_finish=0; Ready=1 and Done_pulse 1 cycle at t+34; with the datapath attached, Product=64'd15.
2. Operands 0xFFFFFFFF × 0xFFFFFFFF → same 34-cycle timing; Product=0xFFFFFFFE00000001; Multiplicand holds 0xFFFFFFFF throughout.
3. Start pulses during RUN, and Multiplicand_in changed to 0x12345678 mid-RUN → no restart; Count sequence 0..31 unbroken; latched operands unchanged.
4. Hold Ready without Ack for 10 cycles → Ready stays 1, Done_pulse only on the first cycle, Run=0; Ack=1 → IDLE next cycle, Ready=0.
5. Reset asserted at Count=10 → next cycle IDLE, Count=0, Run=0, pre_finish=1, operands 0; Ready never asserts; a subsequent Start runs a full 34-cycle op.
6. Start+Ack together in DONE → IDLE, no Load; Start in the following cycle → Load one cycle later.
